booth_dot_pipe: RTL

Parametrised, pipelined radix-4 Booth dot-product accumulator for the NPU MAC array. Each cycle it multiplies LANES operand pairs of DATA_W bits in signed or unsigned mode. It reduces the Booth partial products and sign-extension constants of all lanes into one beat sum. Beat sums are accumulated with saturation across a packet delimited by `in_last`. It replaces per-lane fixed 8-bit partial-product generation plus external summation with one self-contained 3-stage block.

---
 rtl/booth_dot_pipe_if.sv | 31 +++
 rtl/booth_dot_pipe.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/booth_dot_pipe_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | booth_dot_pipe_if                                                     |
// | Beat input / packet result bundle for booth_dot_pipe.                 |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface booth_dot_pipe_if #(
   parameter int DATA_W = 8,
   parameter int LANES  = 9,
   parameter int ACC_W  = 32
);
   logic                      in_valid;
   logic                      in_last;
   logic                      in_unsigned;
   logic [LANES*DATA_W-1:0]   multiplicand;
   logic [LANES*DATA_W-1:0]   multiplier;
   logic                      out_valid;
   logic signed [ACC_W-1:0]   out_sum;
   logic                      out_sat;

   modport master (
      output in_valid, in_last, in_unsigned, multiplicand, multiplier,
      input  out_valid, out_sum, out_sat
   );

   modport slave (
      input  in_valid, in_last, in_unsigned, multiplicand, multiplier,
      output out_valid, out_sum, out_sat
   );
endinterface
`default_nettype wire

// File: rtl/booth_dot_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | booth_dot_pipe                                                        |
// | Radix-4 Booth dot-product with saturating per-packet accumulation.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module booth_dot_pipe #(
   parameter int DATA_W = 8,
   parameter int LANES  = 9,
   parameter int ACC_W  = 32
) (
   input  logic            clk,
   input  logic            reset,
   booth_dot_pipe_if.slave bus
);
   localparam int c_ND    = DATA_W / 2 + 1;
   localparam int c_XW    = DATA_W + 2;
   localparam int c_PP_W  = DATA_W + 3;
   localparam int c_BS_W  = 2 * DATA_W + 2 + $clog2(LANES);
   localparam int c_SUM_W = ((ACC_W > c_BS_W) ? ACC_W : c_BS_W) + 1;

   localparam logic [c_PP_W-1:0] c_PP_MSB = c_PP_W'(1) << (c_PP_W - 1);

   // Each partial product carries an inverted MSB, so every one needs -2^(PP_W-1) at its weight.
   function automatic logic [c_BS_W-1:0] f_fold_const();
      logic [c_BS_W-1:0] v;
      v = '0;
      for (int l = 0; l < LANES; l++)
         for (int j = 0; j < c_ND; j++)
            v = v - (c_BS_W'(1) << (c_PP_W - 1 + 2 * j));
      return v;
   endfunction

   localparam logic [c_BS_W-1:0]         c_FOLD = f_fold_const();
   localparam logic signed [c_SUM_W-1:0] c_ZERO = '0;
   localparam logic signed [c_SUM_W-1:0] c_MAX  = (c_SUM_W'(1) << (ACC_W - 1)) - c_SUM_W'(1);
   localparam logic signed [c_SUM_W-1:0] c_MIN  = c_ZERO - (c_SUM_W'(1) << (ACC_W - 1));

   logic [LANES*DATA_W-1:0] r_mc;
   logic [LANES*DATA_W-1:0] r_mp;
   logic                    r_uns0;
   logic                    r_v0;
   logic                    r_last0;

   logic [c_XW-1:0]   w_x   [LANES];
   logic [c_XW:0]     w_yz  [LANES];
   logic [2:0]        w_dig [LANES][c_ND];
   logic [c_PP_W-1:0] w_sel [LANES][c_ND];
   logic [c_PP_W-1:0] w_pp  [LANES][c_ND];
   logic              w_neg [LANES][c_ND];

   logic [c_PP_W-1:0] r_pp  [LANES][c_ND];
   logic              r_neg [LANES][c_ND];
   logic              r_v1;
   logic              r_last1;

   logic [c_BS_W-1:0]        w_bs;
   logic signed [c_BS_W-1:0] r_bs;
   logic                     r_v2;
   logic                     r_last2;

   logic signed [ACC_W-1:0]   r_acc;
   logic                      r_first;
   logic                      r_sat;
   logic                      r_out_valid;
   logic signed [ACC_W-1:0]   r_out_sum;
   logic                      r_out_sat;

   logic signed [c_SUM_W-1:0] w_acc_ext;
   logic signed [c_SUM_W-1:0] w_bs_ext;
   logic signed [c_SUM_W-1:0] w_r;
   logic signed [ACC_W-1:0]   w_clamp;
   logic                      w_ovf;

   // Operands are captured first so PPG starts from a register boundary.
   always_ff @(posedge clk) begin
      r_mc   <= bus.multiplicand;
      r_mp   <= bus.multiplier;
      r_uns0 <= bus.in_unsigned;
      r_pp   <= w_pp;
      r_neg  <= w_neg;
      r_bs   <= w_bs;
   end

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         w_x[l]  = r_uns0 ? {2'b00, r_mc[l*DATA_W +: DATA_W]}
                          : {{2{r_mc[l*DATA_W+DATA_W-1]}}, r_mc[l*DATA_W +: DATA_W]};
         w_yz[l] = r_uns0 ? {2'b00, r_mp[l*DATA_W +: DATA_W], 1'b0}
                          : {{2{r_mp[l*DATA_W+DATA_W-1]}}, r_mp[l*DATA_W +: DATA_W], 1'b0};
         for (int j = 0; j < c_ND; j++) begin
            w_dig[l][j] = w_yz[l][2*j +: 3];
            case (w_dig[l][j])
               3'b001, 3'b010, 3'b101, 3'b110: w_sel[l][j] = {w_x[l][c_XW-1], w_x[l]};
               3'b011, 3'b100:                 w_sel[l][j] = {w_x[l], 1'b0};
               default:                        w_sel[l][j] = '0;
            endcase
            w_neg[l][j] = w_dig[l][j][2] & ~(w_dig[l][j][1] & w_dig[l][j][0]);
            w_pp[l][j]  = w_sel[l][j] ^ {c_PP_W{w_neg[l][j]}} ^ c_PP_MSB;
         end
      end
   end

   // Modular sum in BS_W bits; the true beat sum always fits, so wrap of the fold constant cancels.
   always_comb begin
      w_bs = c_FOLD;
      for (int l = 0; l < LANES; l++)
         for (int j = 0; j < c_ND; j++)
            w_bs = w_bs + (c_BS_W'(r_pp[l][j]) << (2 * j)) + (c_BS_W'(r_neg[l][j]) << (2 * j));
   end

   assign w_acc_ext = {{(c_SUM_W - ACC_W){r_acc[ACC_W-1]}}, r_acc};
   assign w_bs_ext  = {{(c_SUM_W - c_BS_W){r_bs[c_BS_W-1]}}, r_bs};

   always_comb begin
      w_r     = (r_first ? c_ZERO : w_acc_ext) + w_bs_ext;
      w_ovf   = 1'b0;
      w_clamp = w_r[ACC_W-1:0];
      if (w_r > c_MAX) begin
         w_clamp = c_MAX[ACC_W-1:0];
         w_ovf   = 1'b1;
      end else if (w_r < c_MIN) begin
         w_clamp = c_MIN[ACC_W-1:0];
         w_ovf   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_v0        <= 1'b0;
         r_last0     <= 1'b0;
         r_v1        <= 1'b0;
         r_last1     <= 1'b0;
         r_v2        <= 1'b0;
         r_last2     <= 1'b0;
         r_acc       <= '0;
         r_first     <= 1'b1;
         r_sat       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_sat   <= 1'b0;
      end else begin
         r_v0        <= bus.in_valid;
         r_last0     <= bus.in_valid & bus.in_last;
         r_v1        <= r_v0;
         r_last1     <= r_last0;
         r_v2        <= r_v1;
         r_last2     <= r_last1;
         r_out_valid <= 1'b0;
         if (r_v2) begin
            r_acc <= w_clamp;
            if (r_last2) begin
               r_out_sum   <= w_clamp;
               r_out_sat   <= r_sat | w_ovf;
               r_out_valid <= 1'b1;
               r_first     <= 1'b1;
               r_sat       <= 1'b0;
            end else begin
               r_first <= 1'b0;
               r_sat   <= r_sat | w_ovf;
            end
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_sum   = r_out_sum;
   assign bus.out_sat   = r_out_sat;

endmodule
`default_nettype wire
